// File: rtl/mem_pkg.sv
// Shared types for the store buffer in front of the data memory.
// Holds the address/data widths and the packed layout of one queued store.
package mem_pkg;

    localparam int AW = 32;
    localparam int DW = 32;

    // One posted store waiting to be written into mem.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular FIFO of posted stores.
// Power-of-two depth, so head/tail wrap by plain overflow.
// With STORE_BUFFER_FWD_EN defined, the entry array, head pointer and count are
// also exported so the top level can search the queued stores by age.
module store_buffer_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  sb_entry_t              push_entry,
    input  logic                   pop,
`ifdef STORE_BUFFER_FWD_EN
    output sb_entry_t [DEPTH-1:0]  entries,
    output logic      [PW-1:0]     head_ptr,
    output logic      [PW:0]       count,
`endif
    output logic                   full,
    output logic                   empty,
    output sb_entry_t              head_entry
);

    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    sb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [PW:0]           count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    // Next-state for pointers, count and the slot written by a push.
    always_comb begin
        do_push   = push && (count_q != FULL_CNT);
        do_pop    = pop && (count_q != '0);
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (do_push) begin
            entries_d[tail_q] = push_entry;
            tail_d            = tail_q + 1'b1;
        end
        if (do_pop) begin
            head_d = head_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the queue and discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are qualified by count so they need no reset.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign head_entry = entries_q[head_q];

`ifdef STORE_BUFFER_FWD_EN
    assign entries  = entries_q;
    assign head_ptr = head_q;
    assign count    = count_q;
`endif

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer in front of the data memory.
// Stores are queued and drained one per cycle whenever no load owns mem;
// loads always win the memory port and get their data one cycle later.
// Build option STORE_BUFFER_FWD_EN: loads are always accepted and are served
// from the youngest matching queued store. Without it, loads wait until the
// buffer has drained and always read mem.
// AW/DW must match the widths in mem_pkg, which fix the entry layout.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_resp_vld,
    output logic [DW-1:0] ld_resp_data,
    output logic [AW-1:0] address,
    output logic [DW-1:0] memIn,
    output logic          read,
    output logic          write,
    input  logic [DW-1:0] memOut
);

    import mem_pkg::*;

    logic          fifo_full;
    logic          fifo_empty;
    sb_entry_t     head_entry;
    sb_entry_t     push_entry;
    logic          push;
    logic          ld_acc;
    logic          drain;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    logic [AW-1:0] address_q, address_d;
    logic [DW-1:0] mem_in_q, mem_in_d;
    logic          ld_resp_vld_q, ld_resp_vld_d;
    logic [DW-1:0] ld_resp_data_q, ld_resp_data_d;

`ifdef STORE_BUFFER_FWD_EN
    localparam int PW = $clog2(DEPTH);
    sb_entry_t [DEPTH-1:0] fifo_entries;
    logic [PW-1:0]         fifo_head;
    logic [PW-1:0]         fwd_idx;
    logic [PW:0]           fifo_count;
`endif

    // Accept a store only on registered space; a drain in the same cycle does not help.
    assign st_ready        = !fifo_full;
    assign push            = st_valid && st_ready;
    assign push_entry.addr = st_addr;
    assign push_entry.data = st_data;

    store_buffer_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
`ifdef STORE_BUFFER_FWD_EN
        .entries    (fifo_entries),
        .head_ptr   (fifo_head),
        .count      (fifo_count),
`endif
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_entry (head_entry)
    );

    // No load is taken while reset is asserted, so mem stays untouched then.
`ifdef STORE_BUFFER_FWD_EN
    assign ld_ready = rst_n;
`else
    assign ld_ready = rst_n && fifo_empty;
`endif

`ifdef STORE_BUFFER_FWD_EN
    // Walk queued stores oldest to youngest so the youngest address match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = fifo_head + PW'(k);
            if (((PW + 1)'(k) < fifo_count) && (fifo_entries[fwd_idx].addr == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_entries[fwd_idx].data;
            end
        end
    end
`else
    // Loads only run against an empty buffer, so mem is always current.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
    end
`endif

    // Memory port arbitration: an accepted load owns mem, otherwise drain the head.
    always_comb begin
        ld_acc    = ld_valid && ld_ready;
        drain     = !ld_acc && !fifo_empty;
        address_d = address_q;
        mem_in_d  = mem_in_q;
        if (ld_acc) begin
            address_d = ld_addr;
        end else if (drain) begin
            address_d = head_entry.addr;
            mem_in_d  = head_entry.data;
        end
        read    = ld_acc;
        write   = drain;
        address = address_d;
        memIn   = mem_in_d;
    end

    // Load response capture: forwarded data on a hit, else the combinational mem read.
    always_comb begin
        ld_resp_vld_d  = ld_acc;
        ld_resp_data_d = ld_resp_data_q;
        if (ld_acc) begin
            ld_resp_data_d = fwd_hit ? fwd_data : memOut;
        end
    end

    // Registered port state: held address/data for idle cycles plus the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address_q      <= '0;
            mem_in_q       <= '0;
            ld_resp_vld_q  <= 1'b0;
            ld_resp_data_q <= '0;
        end else begin
            address_q      <= address_d;
            mem_in_q       <= mem_in_d;
            ld_resp_vld_q  <= ld_resp_vld_d;
            ld_resp_data_q <= ld_resp_data_d;
        end
    end

    assign ld_resp_vld  = ld_resp_vld_q;
    assign ld_resp_data = ld_resp_data_q;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer; honours STORE_BUFFER_FWD_EN like the design.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid, st_ready;
    logic [31:0] st_addr, st_data;
    logic        ld_valid, ld_ready;
    logic [31:0] ld_addr;
    logic        ld_resp_vld;
    logic [31:0] ld_resp_data;
    logic [31:0] address, memIn, memOut;
    logic        read, write;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_resp_vld(ld_resp_vld), .ld_resp_data(ld_resp_data),
        .address(address), .memIn(memIn), .read(read), .write(write), .memOut(memOut)
    );

    // Memory model: combinational read, write on posedge.
    logic [31:0] mem    [256];
    logic [31:0] shadow [256];
    assign memOut = mem[address[7:0]];
    always @(posedge clk) if (write) mem[address[7:0]] <= memIn;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          wr_in_reset = 0;
    logic [31:0] expq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    // Scoreboard: expected data is the latest value stored in program order,
    // captured when the load is accepted (before a same-cycle store).
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            if (write) wr_in_reset++;
        end else begin
            if (ld_resp_vld) begin
                if (expq.size() == 0) bound_fail("unexpected_ld_resp");
                else check("sb_ld_resp_data", ld_resp_data, expq.pop_front());
            end
            if (ld_valid && ld_ready) expq.push_back(shadow[ld_addr[7:0]]);
            if (st_valid && st_ready) shadow[st_addr[7:0]] = st_data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_in();
        st_valid = 1'b0;
        ld_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        idle_in();
        for (int k = 0; k < 20; k++) begin
            settle();
            if (!write) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        if (!ok) bound_fail("wait_drain");
        cyc();
    endtask

    task automatic do_load(input logic [31:0] a);
        bit ok;
        ok = 1'b0;
        st_valid = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = a;
        for (int k = 0; k < 20; k++) begin
            settle();
            if (ld_ready) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        if (!ok) bound_fail("do_load_ready");
        cyc();
        ld_valid = 1'b0;
    endtask

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        lv;
        logic [31:0] la;
        logic        ew;
        logic        er;
        logic [31:0] ea;
        logic [31:0] emi;
    } vec_t;

    vec_t vt[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 32'h5EED0000 + i;
            shadow[i] = 32'h5EED0000 + i;
        end
        vt[0] = '{1'b1, 32'd16, 32'h12345678, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0,  32'h0};
        vt[1] = '{1'b1, 32'd24, 32'h89abcdef, 1'b0, 32'd0,  1'b1, 1'b0, 32'd16, 32'h12345678};
        vt[2] = '{1'b0, 32'd0,  32'h0,        1'b0, 32'd0,  1'b1, 1'b0, 32'd24, 32'h89abcdef};
        vt[3] = '{1'b0, 32'd0,  32'h0,        1'b0, 32'd0,  1'b0, 1'b0, 32'd24, 32'h89abcdef};
        vt[4] = '{1'b0, 32'd0,  32'h0,        1'b1, 32'd16, 1'b0, 1'b1, 32'd16, 32'h89abcdef};
        vt[5] = '{1'b0, 32'd0,  32'h0,        1'b1, 32'd20, 1'b0, 1'b1, 32'd20, 32'h89abcdef};
        vt[6] = '{1'b0, 32'd0,  32'h0,        1'b1, 32'd24, 1'b0, 1'b1, 32'd24, 32'h89abcdef};
        vt[7] = '{1'b0, 32'd0,  32'h0,        1'b0, 32'd0,  1'b0, 1'b0, 32'd24, 32'h89abcdef};

        // Reset held with a store offered: nothing enqueued, outputs zero.
        rst_n    = 1'b0;
        st_valid = 1'b1;
        st_addr  = 32'd8;
        st_data  = 32'hDEADBEEF;
        ld_valid = 1'b0;
        ld_addr  = 32'd0;
        repeat (3) cyc();
        settle();
        check("rst_write", {31'd0, write}, 32'd0);
        check("rst_read", {31'd0, read}, 32'd0);
        check("rst_address", address, 32'd0);
        check("rst_memIn", memIn, 32'd0);
        check("rst_ld_resp_vld", {31'd0, ld_resp_vld}, 32'd0);
        check("rst_ld_resp_data", ld_resp_data, 32'd0);
        st_valid = 1'b0;
        rst_n    = 1'b1;
        cyc();
        settle();
        check("post_rst_st_ready", {31'd0, st_ready}, 32'd1);
        check("post_rst_no_write", {31'd0, write}, 32'd0);
        cyc();

        // Two stores drain on consecutive cycles, then loads read them back.
        for (int i = 0; i < 8; i++) begin
            st_valid = vt[i].sv;
            st_addr  = vt[i].sa;
            st_data  = vt[i].sd;
            ld_valid = vt[i].lv;
            ld_addr  = vt[i].la;
            settle();
            check($sformatf("vec%0d_write", i), {31'd0, write}, {31'd0, vt[i].ew});
            check($sformatf("vec%0d_read", i), {31'd0, read}, {31'd0, vt[i].er});
            check($sformatf("vec%0d_address", i), address, vt[i].ea);
            check($sformatf("vec%0d_memIn", i), memIn, vt[i].emi);
            check($sformatf("vec%0d_st_ready", i), {31'd0, st_ready}, 32'd1);
            cyc();
        end
        idle_in();
        cyc();

        // Fill under continuous loads, then release and watch the drain.
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1;
            st_addr  = 32'd64 + 32'(4 * i);
            st_data  = 32'hC3000000 + 32'(i);
            ld_valid = 1'b1;
            ld_addr  = 32'd100;
            settle();
            check($sformatf("fill%0d_st_ready", i), {31'd0, st_ready}, 32'd1);
`ifdef STORE_BUFFER_FWD_EN
            check($sformatf("fill%0d_read", i), {31'd0, read}, 32'd1);
            check($sformatf("fill%0d_write", i), {31'd0, write}, 32'd0);
`else
            if (i == 0) begin
                check("fill0_ld_ready", {31'd0, ld_ready}, 32'd1);
            end else begin
                check($sformatf("fill%0d_ld_ready", i), {31'd0, ld_ready}, 32'd0);
                check($sformatf("fill%0d_write", i), {31'd0, write}, 32'd1);
            end
`endif
            cyc();
        end
        st_valid = 1'b1;
        st_addr  = 32'd80;
        st_data  = 32'hC3000004;
        ld_valid = 1'b0;
        settle();
`ifdef STORE_BUFFER_FWD_EN
        check("full_st_ready", {31'd0, st_ready}, 32'd0);
        check("full_drain_write", {31'd0, write}, 32'd1);
        check("full_drain_address", address, 32'd64);
        cyc();
        settle();
        check("after_pop_st_ready", {31'd0, st_ready}, 32'd1);
        check("second_drain_address", address, 32'd68);
        cyc();
`else
        check("nofwd_st_ready", {31'd0, st_ready}, 32'd1);
        check("nofwd_drain_address", address, 32'd76);
        cyc();
`endif
        wait_drain();
        for (int i = 0; i < 5; i++) do_load(32'd64 + 32'(4 * i));
        cyc();

        // Two stores to one address, then a load before the buffer drains.
        st_valid = 1'b1; st_addr = 32'd32; st_data = 32'hAAAA0001;
        ld_valid = 1'b1; ld_addr = 32'd200;
        cyc();
        st_data = 32'hAAAA0002;
        cyc();
        st_valid = 1'b0;
        ld_addr  = 32'd32;
        settle();
`ifdef STORE_BUFFER_FWD_EN
        check("fwd_ld_ready", {31'd0, ld_ready}, 32'd1);
        check("fwd_read", {31'd0, read}, 32'd1);
        check("fwd_address", address, 32'd32);
        cyc();
`else
        check("stall_ld_ready", {31'd0, ld_ready}, 32'd0);
        do_load(32'd32);
`endif
        ld_valid = 1'b0;
        settle();
        check("fwd_resp_vld", {31'd0, ld_resp_vld}, 32'd1);
        check("fwd_resp_data", ld_resp_data, 32'hAAAA0002);
        cyc();
        settle();
        check("resp_one_cycle", {31'd0, ld_resp_vld}, 32'd0);
        cyc();
        wait_drain();

        // Same-cycle load and store: the load is ordered first.
        st_valid = 1'b1; st_addr = 32'd32; st_data = 32'hAAAA0003;
        ld_valid = 1'b1; ld_addr = 32'd32;
        cyc();
        idle_in();
        settle();
        check("order_resp_data", ld_resp_data, 32'hAAAA0002);
        cyc();
        wait_drain();
        do_load(32'd32);
        settle();
        check("order_reload_data", ld_resp_data, 32'hAAAA0003);
        cyc();

        // Reset asserted mid-drain discards the queued stores.
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1;
            st_addr  = 32'd40 + 32'(4 * i);
            st_data  = 32'hBB000000 + 32'(i);
            ld_valid = 1'b1;
            ld_addr  = 32'd200;
            cyc();
        end
        idle_in();
        settle();
        check("mid_drain_write", {31'd0, write}, 32'd1);
`ifdef STORE_BUFFER_FWD_EN
        check("mid_drain_address", address, 32'd40);
`else
        check("mid_drain_address", address, 32'd48);
`endif
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst2_write", {31'd0, write}, 32'd0);
        check("rst2_read", {31'd0, read}, 32'd0);
        check("rst2_address", address, 32'd0);
        check("rst2_st_ready", {31'd0, st_ready}, 32'd1);
        check("rst2_ld_resp_vld", {31'd0, ld_resp_vld}, 32'd0);
        repeat (2) cyc();
        rst_n = 1'b1;
        check("rst2_writes_during_reset", 32'(wr_in_reset), 32'd0);
        for (int i = 0; i < 256; i++) shadow[i] = mem[i];
`ifdef STORE_BUFFER_FWD_EN
        check("discard_mem44", mem[44], 32'h5EED002C);
        check("discard_mem48", mem[48], 32'h5EED0030);
`endif
        settle();
        check("post_rst2_no_write", {31'd0, write}, 32'd0);
        cyc();
        settle();
        check("post_rst2_no_write_b", {31'd0, write}, 32'd0);
        cyc();
        do_load(32'd16);
        settle();
        check("post_rst2_load16", ld_resp_data, 32'h12345678);
        repeat (3) cyc();
        check("scoreboard_empty", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
